// File: rtl/multi_cycle_control_unit.sv
// Control unit for a pipelined core: same-cycle decode of data-processing, memory
// and branch instructions, plus sequencing of block transfers into per-register micro-ops.
module multi_cycle_control_unit #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    input  logic                hazard,
    input  logic                flush,
    input  logic [1:0]          mode,
    input  logic [3:0]          opcode,
    input  logic                S,
    input  logic [NUM_REGS-1:0] reg_list,
    output logic                B,
    output logic                update_status_reg,
    output logic                WB_Enable,
    output logic                mem_read,
    output logic                mem_write,
    output logic [3:0]          execute_command,
    output logic [IDX_W-1:0]    uop_reg,
    output logic [IDX_W:0]      uop_offset,
    output logic                uop_active,
    output logic                stall
);

    localparam int unsigned OFF_W = IDX_W + 1;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;
    localparam logic [1:0] MODE_BLK = 2'b11;

    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_MEM = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0010;

    if (2 ** IDX_W != NUM_REGS) begin : g_param_check
        $error("multi_cycle_control_unit: 2**IDX_W must equal NUM_REGS");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BURST = 2'b01
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_REGS-1:0]   remaining_q, remaining_d;
    logic [OFF_W-1:0]      counter_q, counter_d;

    // Data-processing opcode to ALU command.
    function automatic logic [3:0] dp_cmd(input logic [3:0] op);
        case (op)
            4'b1101: dp_cmd = 4'b0001;
            4'b1111: dp_cmd = 4'b1001;
            4'b0100: dp_cmd = 4'b0010;
            4'b0101: dp_cmd = 4'b0011;
            4'b0010: dp_cmd = 4'b0100;
            4'b0110: dp_cmd = 4'b0101;
            4'b0000: dp_cmd = 4'b0110;
            4'b1100: dp_cmd = 4'b0111;
            4'b0001: dp_cmd = 4'b1000;
            4'b1010: dp_cmd = 4'b0100;
            4'b1000: dp_cmd = 4'b0110;
            default: dp_cmd = 4'b0000;
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_REGS-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    function automatic logic [NUM_REGS-1:0] clear_lowest(input logic [NUM_REGS-1:0] v);
        clear_lowest = v & (v - NUM_REGS'(1));
    endfunction

    // Next-state and same-cycle control decode; priority rst > flush > hazard > decode.
    always_comb begin
        state_d           = state_q;
        remaining_d       = remaining_q;
        counter_d         = counter_q;
        B                 = 1'b0;
        update_status_reg = 1'b0;
        WB_Enable         = 1'b0;
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        execute_command   = 4'b0000;
        uop_reg           = '0;
        uop_offset        = '0;
        uop_active        = 1'b0;
        stall             = 1'b0;

        if (rst) begin
            state_d     = IDLE;
            remaining_d = '0;
            counter_d   = '0;
        end else if (flush) begin
            state_d     = IDLE;
            remaining_d = '0;
            counter_d   = '0;
        end else if (hazard) begin
            stall = (state_q == BURST);
        end else begin
            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        case (mode)
                            MODE_DP: begin
                                execute_command   = dp_cmd(opcode);
                                update_status_reg = S;
                                WB_Enable         = (dp_cmd(opcode) != 4'b0000) &&
                                                    (opcode != OP_CMP) && (opcode != OP_TST);
                            end
                            MODE_MEM: begin
                                if (opcode == OP_MEM) begin
                                    execute_command = CMD_ADD;
                                    mem_write       = S;
                                    mem_read        = ~S;
                                    WB_Enable       = ~S;
                                end
                            end
                            MODE_BR: begin
                                B = 1'b1;
                            end
                            MODE_BLK: begin
                                if (reg_list != '0) begin
                                    execute_command = CMD_ADD;
                                    mem_write       = S;
                                    mem_read        = ~S;
                                    WB_Enable       = ~S;
                                    uop_active      = 1'b1;
                                    uop_reg         = lowest_idx(reg_list);
                                    uop_offset      = '0;
                                    remaining_d     = clear_lowest(reg_list);
                                    counter_d       = OFF_W'(1);
                                    if (clear_lowest(reg_list) != '0) begin
                                        stall   = 1'b1;
                                        state_d = BURST;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                BURST: begin
                    // IF/ID is frozen here, so mode/S still describe the block instruction.
                    execute_command = CMD_ADD;
                    mem_write       = S;
                    mem_read        = ~S;
                    WB_Enable       = ~S;
                    uop_active      = 1'b1;
                    uop_reg         = lowest_idx(remaining_q);
                    uop_offset      = counter_q;
                    remaining_d     = clear_lowest(remaining_q);
                    counter_d       = counter_q + OFF_W'(1);
                    if (clear_lowest(remaining_q) != '0) begin
                        stall = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            counter_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            counter_q   <= counter_d;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Bench for multi_cycle_control_unit: directed vector table for the block-transfer
// corner cases, then randomized traffic checked against a queue-based reference model.
module tb_multi_cycle_control_unit;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        hazard;
    logic        flush;
    logic [1:0]  mode;
    logic [3:0]  opcode;
    logic        S;
    logic [15:0] reg_list;
    logic        B, update_status_reg, WB_Enable, mem_read, mem_write;
    logic [3:0]  execute_command;
    logic [3:0]  uop_reg;
    logic [4:0]  uop_offset;
    logic        uop_active;
    logic        stall;

    int checks;
    int failures;

    multi_cycle_control_unit #(.NUM_REGS(16), .IDX_W(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .instr_valid       (instr_valid),
        .hazard            (hazard),
        .flush             (flush),
        .mode              (mode),
        .opcode            (opcode),
        .S                 (S),
        .reg_list          (reg_list),
        .B                 (B),
        .update_status_reg (update_status_reg),
        .WB_Enable         (WB_Enable),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .execute_command   (execute_command),
        .uop_reg           (uop_reg),
        .uop_offset        (uop_offset),
        .uop_active        (uop_active),
        .stall             (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle layout: {B,usr,wb,mr,mw,cmd[3:0],uop_reg[3:0],uop_offset[4:0],uop_active,stall}
    function automatic logic [19:0] ex(input logic b, input logic usr, input logic wb,
                                       input logic mr, input logic mw, input logic [3:0] cmd,
                                       input int r, input int off, input logic ua, input logic st);
        ex = {b, usr, wb, mr, mw, cmd, 4'(r), 5'(off), ua, st};
    endfunction

    function automatic logic [19:0] uop(input logic store, input int r, input int off, input logic st);
        uop = ex(1'b0, 1'b0, ~store, ~store, store, 4'b0010, r, off, 1'b1, st);
    endfunction

    function automatic logic [19:0] got_bundle();
        got_bundle = {B, update_status_reg, WB_Enable, mem_read, mem_write, execute_command,
                      uop_reg, uop_offset, uop_active, stall};
    endfunction

    task automatic check(input string name, input logic [19:0] got, input logic [19:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%05h exp=%05h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        rst, iv, hz, fl;
        logic [1:0]  mode;
        logic [3:0]  op;
        logic        s;
        logic [15:0] rl;
        logic [19:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic r, input logic iv, input logic hz,
                       input logic fl, input logic [1:0] m, input logic [3:0] op,
                       input logic s, input logic [15:0] rl, input logic [19:0] e);
        vec_t v;
        v.rst = r; v.iv = iv; v.hz = hz; v.fl = fl; v.mode = m; v.op = op;
        v.s = s; v.rl = rl; v.exp = e; v.name = name;
        vecs.push_back(v);
    endtask

    // Reference model: pending registers kept as an ordered queue of indices.
    logic [3:0] dp_map [16];
    int         pend_q[$];
    int         next_off;
    logic       held_s;

    task automatic model_step(input logic r, input logic iv, input logic hz, input logic fl,
                              input logic [1:0] m, input logic [3:0] op, input logic s,
                              input logic [15:0] rl, output logic [19:0] e);
        int idx;
        e = '0;
        if (r) begin
            pend_q.delete();
            next_off = 0;
        end else if (fl) begin
            pend_q.delete();
        end else if (hz) begin
            e = ex(0, 0, 0, 0, 0, 4'b0, 0, 0, 0, pend_q.size() != 0);
        end else if (pend_q.size() != 0) begin
            idx = pend_q.pop_front();
            e = uop(held_s, idx, next_off, pend_q.size() != 0);
            next_off++;
        end else if (iv) begin
            case (m)
                2'd0: e = ex(0, s, (dp_map[op] != 0) && op != 4'd10 && op != 4'd8,
                             0, 0, dp_map[op], 0, 0, 0, 0);
                2'd1: if (op == 4'd2) e = ex(0, 0, ~s, ~s, s, 4'b0010, 0, 0, 0, 0);
                2'd2: e = ex(1, 0, 0, 0, 0, 4'b0, 0, 0, 0, 0);
                default: begin
                    for (int i = 0; i < 16; i++) if (rl[i]) pend_q.push_back(i);
                    if (pend_q.size() != 0) begin
                        idx = pend_q.pop_front();
                        held_s = s;
                        e = uop(s, idx, 0, pend_q.size() != 0);
                        next_off = 1;
                    end
                end
            endcase
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic hz, input logic fl,
                         input logic [1:0] m, input logic [3:0] op, input logic s,
                         input logic [15:0] rl);
        rst = r; instr_valid = iv; hazard = hz; flush = fl;
        mode = m; opcode = op; S = s; reg_list = rl;
    endtask

    logic [19:0] inert;
    logic [19:0] inert_st;

    initial begin
        logic [19:0] e;
        logic        r_rst, r_iv, r_hz, r_fl, r_s;
        logic [1:0]  r_mode;
        logic [3:0]  r_op;
        logic [15:0] r_rl;

        checks = 0;
        failures = 0;
        inert    = ex(0, 0, 0, 0, 0, 4'b0, 0, 0, 0, 0);
        inert_st = ex(0, 0, 0, 0, 0, 4'b0, 0, 0, 0, 1);

        for (int i = 0; i < 16; i++) dp_map[i] = 4'b0000;
        dp_map[13] = 4'b0001; dp_map[15] = 4'b1001; dp_map[4]  = 4'b0010;
        dp_map[5]  = 4'b0011; dp_map[2]  = 4'b0100; dp_map[6]  = 4'b0101;
        dp_map[0]  = 4'b0110; dp_map[12] = 4'b0111; dp_map[1]  = 4'b1000;
        dp_map[10] = 4'b0100; dp_map[8]  = 4'b0110;
        next_off = 0;
        held_s   = 1'b0;

        //   name        rst iv hz fl mode  op     S  reg_list   expected
        add("reset",      1, 1, 0, 0, 2'd0, 4'hD, 0, 16'h0000, inert);
        add("dp_add_s",   0, 1, 0, 0, 2'd0, 4'h4, 1, 16'h0000, ex(0,1,1,0,0,4'b0010,0,0,0,0));
        add("dp_cmp",     0, 1, 0, 0, 2'd0, 4'hA, 0, 16'h0000, ex(0,0,0,0,0,4'b0100,0,0,0,0));
        add("branch",     0, 1, 0, 0, 2'd2, 4'h0, 0, 16'h0000, ex(1,0,0,0,0,4'b0000,0,0,0,0));
        add("ldr",        0, 1, 0, 0, 2'd1, 4'h2, 0, 16'h0000, ex(0,0,1,1,0,4'b0010,0,0,0,0));
        add("str",        0, 1, 0, 0, 2'd1, 4'h2, 1, 16'h0000, ex(0,0,0,0,1,4'b0010,0,0,0,0));
        add("mem_badop",  0, 1, 0, 0, 2'd1, 4'h4, 0, 16'h0000, inert);
        add("invalid",    0, 0, 0, 0, 2'd0, 4'h4, 1, 16'h0000, inert);
        add("ldm8025_0",  0, 1, 0, 0, 2'd3, 4'h0, 0, 16'h8025, uop(0, 0, 0, 1));
        add("ldm8025_1",  0, 0, 0, 0, 2'd3, 4'h0, 0, 16'h8025, uop(0, 2, 1, 1));
        add("ldm8025_2",  0, 1, 0, 0, 2'd3, 4'h0, 0, 16'h8025, uop(0, 5, 2, 1));
        add("ldm8025_3",  0, 0, 0, 0, 2'd3, 4'h0, 0, 16'h8025, uop(0, 15, 3, 0));
        add("post_idle",  0, 0, 0, 0, 2'd3, 4'h0, 0, 16'h8025, inert);
        add("stm_single", 0, 1, 0, 0, 2'd3, 4'h0, 1, 16'h0010, uop(1, 4, 0, 0));
        add("blk_empty",  0, 1, 0, 0, 2'd3, 4'h0, 1, 16'h0000, inert);
        add("haz_0",      0, 1, 0, 0, 2'd3, 4'h0, 0, 16'h00F0, uop(0, 4, 0, 1));
        add("haz_hold",   0, 1, 1, 0, 2'd3, 4'h0, 0, 16'h00F0, inert_st);
        add("haz_1",      0, 1, 0, 0, 2'd3, 4'h0, 0, 16'h00F0, uop(0, 5, 1, 1));
        add("haz_2",      0, 1, 0, 0, 2'd3, 4'h0, 0, 16'h00F0, uop(0, 6, 2, 1));
        add("haz_3",      0, 1, 0, 0, 2'd3, 4'h0, 0, 16'h00F0, uop(0, 7, 3, 0));
        add("fl_0",       0, 1, 0, 0, 2'd3, 4'h0, 1, 16'hFFFF, uop(1, 0, 0, 1));
        add("fl_1",       0, 1, 0, 0, 2'd3, 4'h0, 1, 16'hFFFF, uop(1, 1, 1, 1));
        add("fl_2",       0, 1, 0, 0, 2'd3, 4'h0, 1, 16'hFFFF, uop(1, 2, 2, 1));
        add("fl_kill",    0, 1, 1, 1, 2'd3, 4'h0, 1, 16'hFFFF, inert);
        add("mov_after",  0, 1, 0, 0, 2'd0, 4'hD, 0, 16'h0000, ex(0,0,1,0,0,4'b0001,0,0,0,0));
        add("rst_0",      0, 1, 0, 0, 2'd3, 4'h0, 0, 16'h0F00, uop(0, 8, 0, 1));
        add("rst_1",      0, 1, 0, 0, 2'd3, 4'h0, 0, 16'h0F00, uop(0, 9, 1, 1));
        add("rst_mid",    1, 1, 0, 0, 2'd3, 4'h0, 0, 16'h0F00, inert);
        add("rst_idle",   0, 0, 0, 0, 2'd3, 4'h0, 0, 16'h0F00, inert);
        add("fresh_0",    0, 1, 0, 0, 2'd3, 4'h0, 0, 16'h0F00, uop(0, 8, 0, 1));
        add("fresh_1",    0, 1, 0, 0, 2'd3, 4'h0, 0, 16'h0F00, uop(0, 9, 1, 1));
        add("fresh_2",    0, 1, 0, 0, 2'd3, 4'h0, 0, 16'h0F00, uop(0, 10, 2, 1));
        add("fresh_3",    0, 1, 0, 0, 2'd3, 4'h0, 0, 16'h0F00, uop(0, 11, 3, 0));
        add("all_0",      0, 1, 0, 0, 2'd3, 4'h0, 0, 16'hFFFF, uop(0, 0, 0, 1));
        for (int i = 1; i < 16; i++)
            add($sformatf("all_%0d", i), 0, 1, 0, 0, 2'd3, 4'h0, 0, 16'hFFFF,
                uop(0, i, i, i != 15));
        add("all_done",   0, 0, 0, 0, 2'd0, 4'h0, 0, 16'h0000, inert);

        drive(1, 0, 0, 0, 2'd0, 4'h0, 0, 16'h0);
        @(posedge clk); #1;

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].iv, vecs[k].hz, vecs[k].fl,
                  vecs[k].mode, vecs[k].op, vecs[k].s, vecs[k].rl);
            @(negedge clk);
            check(vecs[k].name, got_bundle(), vecs[k].exp);
            @(posedge clk); #1;
        end

        // Randomized traffic; the model starts from a reset cycle.
        r_mode = 2'd0; r_op = 4'h0; r_s = 1'b0; r_rl = 16'h0;
        pend_q.delete();
        drive(1, 0, 0, 0, 2'd0, 4'h0, 0, 16'h0);
        model_step(1, 0, 0, 0, 2'd0, 4'h0, 0, 16'h0, e);
        @(negedge clk);
        check("rand_reset", got_bundle(), e);
        @(posedge clk); #1;

        for (int n = 0; n < 3000; n++) begin
            r_rst = ($urandom_range(0, 79) == 0);
            r_fl  = ($urandom_range(0, 29) == 0);
            r_hz  = ($urandom_range(0, 7) == 0);
            r_iv  = ($urandom_range(0, 5) != 0);
            if (pend_q.size() == 0) begin
                r_mode = 2'($urandom_range(0, 3));
                r_op   = 4'($urandom_range(0, 15));
                r_s    = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 4))
                    0: r_rl = 16'h0000;
                    1: r_rl = 16'hFFFF;
                    2: r_rl = 16'(1) << $urandom_range(0, 15);
                    default: r_rl = 16'($urandom);
                endcase
                if (r_mode == 2'd1 && $urandom_range(0, 1) == 0) r_op = 4'h2;
            end
            drive(r_rst, r_iv, r_hz, r_fl, r_mode, r_op, r_s, r_rl);
            model_step(r_rst, r_iv, r_hz, r_fl, r_mode, r_op, r_s, r_rl, e);
            @(negedge clk);
            check($sformatf("rand_%0d", n), got_bundle(), e);
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
